// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan driver for a 4-digit common-anode display.
// Frames are scanned digit 0..3, one SCAN_DIV-cycle slot per digit. New values are
// double-buffered and reach the display only at frame boundaries.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading-zero digits, never digit 0).
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    output logic        ready,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        frame_done,
    output logic        active
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_active_val;
    logic [15:0]       r_pending;

    logic              w_tick;
    logic              w_boundary;
    logic              w_scan_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [15:0]       w_val_nxt;
    logic [15:0]       w_shifted;
    logic [3:0]        w_anode_nxt;
    logic [3:0]        w_digit_nxt;

    // Next slot index / displayed value, and the anode/digit pattern they produce
    always_comb begin
        w_tick      = (r_state == ST_SCAN) && (r_cnt == CNT_MAX);
        w_boundary  = w_tick && (r_idx == IDX_LAST);
        w_scan_nxt  = (r_state == ST_SCAN) || load;
        w_idx_nxt   = r_idx;
        w_val_nxt   = r_active_val;
        w_anode_nxt = 4'hF;
        w_digit_nxt = 4'h0;

        if (r_state == ST_IDLE) begin
            if (load) begin
                w_idx_nxt = '0;
                w_val_nxt = value_in;
            end
        end else begin
            if (w_tick) begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
            // Pending value only replaces the display at a frame boundary
            if (w_boundary && !ready) begin
                w_val_nxt = r_pending;
            end
        end

        w_shifted = w_val_nxt >> {w_idx_nxt, 2'b00};

        if (w_scan_nxt) begin
            w_digit_nxt = w_shifted[3:0];
            w_anode_nxt = ~(4'b0001 << w_idx_nxt);
`ifdef LEADING_ZERO_BLANK_EN
            // Upper nibbles all zero from this digit up: leading zero, keep dark
            if ((w_idx_nxt != '0) && (w_shifted == 16'h0000)) begin
                w_anode_nxt = 4'hF;
            end
`endif
        end
    end

    // Scan state machine, prescaler, pending buffer and registered outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_active_val <= '0;
            r_pending    <= '0;
            ready        <= 1'b1;
            anode        <= 4'hF;
            digit        <= 4'h0;
            frame_done   <= 1'b0;
            active       <= 1'b0;
        end else begin
            r_idx        <= w_idx_nxt;
            r_active_val <= w_val_nxt;
            anode        <= w_anode_nxt;
            digit        <= w_digit_nxt;

            case (r_state)
                ST_IDLE: begin
                    frame_done <= 1'b0;
                    r_cnt      <= '0;
                    if (load) begin
                        r_state <= ST_SCAN;
                        active  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_cnt      <= w_tick ? '0 : r_cnt + CNT_W'(1);
                    frame_done <= w_boundary;
                    // ready=1 means the buffer is empty, so a boundary transfer and
                    // a new capture can never coincide
                    if (load && ready) begin
                        r_pending <= value_in;
                        ready     <= 1'b0;
                    end else if (w_boundary && !ready) begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (SCAN_DIV=4). Reference model tracks
// elapsed scan time and derives slot/boundary from plain arithmetic.
module tb_display_scan_ctrl;

    localparam int unsigned SD    = 4;
    localparam int unsigned FRAME = 4 * SD;
    localparam logic [10:0] IDLE_VEC = {1'b1, 4'hF, 4'h0, 1'b0, 1'b0};

    logic        clk_in   = 1'b0;
    logic        reset    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic        ready;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        frame_done;
    logic        active;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_scan = 0;
    int          m_t    = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_full = 0;
    bit          m_fd   = 0;

    display_scan_ctrl #(.SCAN_DIV(SD), .NUM_DIGITS(4)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .load       (load),
        .value_in   (value_in),
        .ready      (ready),
        .anode      (anode),
        .digit      (digit),
        .frame_done (frame_done),
        .active     (active)
    );

    always #5 clk_in = ~clk_in;

    assign obs = {ready, anode, digit, frame_done, active};

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit bnd;
        bit acc;
        if (reset) begin
            m_scan = 0; m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_full = 0; m_fd = 0;
        end else if (!m_scan) begin
            m_fd = 0;
            if (load) begin
                m_scan = 1; m_t = 0; m_disp = value_in;
            end
        end else begin
            bnd  = ((m_t % FRAME) == FRAME - 1);
            acc  = load && !m_full;
            m_fd = bnd;
            if (bnd && m_full) begin
                m_disp = m_pend;
                m_full = 0;
            end
            if (acc) begin
                m_pend = value_in;
                m_full = 1;
            end
            m_t++;
        end
    endtask

    function automatic logic [10:0] exp_vec();
        int          k;
        logic [15:0] sh;
        logic [3:0]  an;
        if (!m_scan) return IDLE_VEC;
        k  = (m_t / SD) % 4;
        sh = m_disp >> (4 * k);
        an = ~(4'b0001 << k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k != 0 && sh == 16'h0) an = 4'hF;
`endif
        return {~m_full, an, sh[3:0], m_fd, 1'b1};
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++; $display("FAIL reset_async got %b want %b", obs, IDLE_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs !== IDLE_VEC) begin
                errors++; $display("FAIL reset_hold got %b want %b", obs, IDLE_VEC);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            value_in = 16'($urandom);
            cycle();
            checks++;
            if (obs !== IDLE_VEC || obs !== exp_vec()) begin
                errors++; $display("FAIL idle_hold cyc %0d got %b want %b", i, obs, IDLE_VEC);
            end
        end
    endtask

    task automatic test_scan_1234();
        logic [7:0] tbl [4];
        tbl[0] = 8'hE4; tbl[1] = 8'hD3; tbl[2] = 8'hB2; tbl[3] = 8'h71;
        load = 1'b1; value_in = 16'h1234;
        cycle();
        load = 1'b0; value_in = 16'h0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL scan1234_model c=%0d got %b want %b", c, obs, exp_vec());
            end
            checks++;
            if ({anode, digit} !== tbl[(c / SD) % 4] || active !== 1'b1) begin
                errors++; $display("FAIL scan1234_slot c=%0d got %h want %h", c, {anode, digit}, tbl[(c / SD) % 4]);
            end
            checks++;
            if (frame_done !== ((c % FRAME) == 0 && c > 0)) begin
                errors++; $display("FAIL scan1234_fd c=%0d got %b", c, frame_done);
            end
            cycle();
        end
    endtask

    task automatic test_pending();
        bit seen = 0;
        while ((m_t % FRAME) != 5) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL pend_pre got %b want %b", obs, exp_vec());
            end
            cycle();
        end
        load = 1'b1; value_in = 16'hABCD;
        cycle();
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL pend_ready_after_load got %b want 0", ready);
        end
        value_in = 16'h5555;
        cycle();
        load = 1'b0; value_in = 16'h0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if (obs !== exp_vec() || digit === 4'h5) begin
                errors++; $display("FAIL pend_model i=%0d got %b want %b", i, obs, exp_vec());
            end
            if (frame_done && !seen) begin
                seen = 1;
                checks++;
                if ({ready, anode, digit} !== {1'b1, 8'hED}) begin
                    errors++; $display("FAIL pend_switch got %h want 1ED", {ready, anode, digit});
                end
            end
            cycle();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL pend_no_frame_done got 0 want 1");
        end
    endtask

    task automatic test_boundary_load();
        while ((m_t % FRAME) != FRAME - 1) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL bnd_pre got %b want %b", obs, exp_vec());
            end
            cycle();
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL bnd_ready_before got %b want 1", ready);
        end
        load = 1'b1; value_in = 16'h00F0;
        cycle();
        load = 1'b0; value_in = 16'h0;
        checks++;
        if ({ready, frame_done, anode, digit} !== {1'b0, 1'b1, 8'hED}) begin
            errors++; $display("FAIL bnd_held got %b want 0_1_ED", {ready, frame_done, anode, digit});
        end
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL bnd_model i=%0d got %b want %b", i, obs, exp_vec());
            end
        end
        checks++;
        if ({ready, frame_done, anode, digit} !== {1'b1, 1'b1, 8'hE0}) begin
            errors++; $display("FAIL bnd_switch got %b want 1_1_E0", {ready, frame_done, anode, digit});
        end
    endtask

    task automatic test_async_reset();
        while ((m_t % FRAME) != 1) cycle();
        load = 1'b1; value_in = 16'h9876;
        cycle();
        load = 1'b0; value_in = 16'h0;
        while ((m_t % FRAME) != 9) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL arst_pre got %b want %b", obs, exp_vec());
            end
            cycle();
        end
        checks++;
        if ({ready, anode} !== {1'b0, 4'hB}) begin
            errors++; $display("FAIL arst_setup got %b want 0_1011", {ready, anode});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++; $display("FAIL arst_immediate got %b want %b", obs, IDLE_VEC);
        end
        cycle();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (obs !== IDLE_VEC || obs !== exp_vec()) begin
                errors++; $display("FAIL arst_idle i=%0d got %b want %b", i, obs, IDLE_VEC);
            end
        end
    endtask

    task automatic test_blank();
        logic [7:0] tbl [4];
`ifdef LEADING_ZERO_BLANK_EN
        tbl[0] = 8'hE0; tbl[1] = 8'hD7; tbl[2] = 8'hF0; tbl[3] = 8'hF0;
`else
        tbl[0] = 8'hE0; tbl[1] = 8'hD7; tbl[2] = 8'hB0; tbl[3] = 8'h70;
`endif
        load = 1'b1; value_in = 16'h0070;
        cycle();
        load = 1'b0; value_in = 16'h0;
        for (int c = 0; c < FRAME + 4; c++) begin
            checks++;
            if (obs !== exp_vec() || {anode, digit} !== tbl[(c / SD) % 4]) begin
                errors++; $display("FAIL blank c=%0d got %h want %h", c, {anode, digit}, tbl[(c / SD) % 4]);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 3) == 0);
            value_in = 16'($urandom);
            reset    = ($urandom_range(0, 199) == 0);
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random i=%0d got %b want %b", i, obs, exp_vec());
            end
        end
        load = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_scan_1234();
        test_pending();
        test_boundary_load();
        test_async_reset();
        test_blank();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter SCAN_DIV, default 100000: clk_in cycles per digit slot; legal range 2..2^24.
REQ-003 Parameter NUM_DIGITS, default 4: digits scanned; fixed at 4 in this revision.
REQ-004 Port clk_in  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port load  input  1  request to accept value_in; taken only while ready=1.
REQ-007 Port value_in  input  16  four BCD/hex nibbles; nibble 0 is the rightmost digit.
REQ-008 Port ready  output  1  high while the pending buffer is empty.
REQ-009 Port anode  output  4  digit enables, active-low, one-hot-low or all high.
REQ-010 Port digit  output  4  nibble for the currently enabled digit.
REQ-011 Port frame_done  output  1  one-cycle pulse at the end of digit-3 slot.
REQ-012 Port active  output  1  high while in SCAN state.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick is asserted in the cycle where count==SCAN_DIV-1.
REQ-014 The state machine SHALL have two states: IDLE (after reset, anode=4'b1111) and SCAN.
REQ-015 IDLE -> SCAN SHALL occur on the first accepted load; the value goes straight to the active register, index=0, and the prescaler restarts at 0, all on the same edge.
REQ-016 SCAN SHALL never return to IDLE except through reset.
REQ-017 In SCAN, index SHALL advance 0->1->2->3->0 on each tick.
REQ-018 In SCAN, anode[index] SHALL be 0 and all other anode bits 1; digit SHALL equal active[4*index+3 : 4*index].
REQ-019 anode, digit, frame_done and active SHALL be driven from registers, with no combinational path from any input.
REQ-020 frame_done SHALL pulse for exactly one cycle, on the cycle after a tick with index==3.
REQ-021 In SCAN, load with ready=1 SHALL capture value_in into the pending buffer and clear ready on the next edge.
REQ-022 load with ready=0 SHALL be ignored, leaving the pending buffer unchanged.
REQ-023 At a frame boundary (tick with index==3) with pending full, pending SHALL move to active and ready SHALL return to 1 on that edge.
REQ-024 When load is accepted in the same cycle as a frame boundary, the new value SHALL stay pending and transfer at the next boundary.
REQ-025 Displayed data SHALL therefore change only at frame boundaries, so no partial frame ever mixes old and new digits.

Reset
REQ-026 While reset=1, the block SHALL force: anode=4'b1111, digit=0, ready=1, frame_done=0, active=0, state=IDLE, index=0, prescaler=0, active and pending registers = 0.
REQ-027 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge, and SHALL discard any pending value.
REQ-028 After reset deasserts, the block SHALL stay in IDLE until the first load.

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN defined: during a slot for digit k>0, anode SHALL be held 4'b1111 when nibbles k..3 of active are all zero; digit 0 SHALL always be shown; slot timing and frame_done SHALL be unchanged.
REQ-030 Macro LEADING_ZERO_BLANK_EN undefined: all four digits SHALL always be enabled in their slots, and no blanking logic SHALL be synthesized.

Verification (SCAN_DIV=4 in simulation)
REQ-031 Reset, then no load for 50 cycles -> anode=1111, ready=1, active=0 throughout.
REQ-032 load value_in=16'h1234 in IDLE -> active=1 next edge; anode/digit sequence 1110/4, 1101/3, 1011/2, 0111/1, 4 cycles each; frame_done pulse every 16 cycles.
REQ-033 In SCAN, load 16'hABCD mid-frame, then load 16'h5555 while ready=0 -> ready low until boundary; next frame shows D,C,B,A; 5555 never appears.
REQ-034 load 16'h00F0 aligned to a boundary tick -> value held pending, ready low; display switches at the following boundary, not the current one.
REQ-035 Assert reset during digit-2 slot with pending full -> outputs at reset values within the same cycle, before the next edge; after release the block stays in IDLE and the pending value is lost.
REQ-036 With LEADING_ZERO_BLANK_EN, display 16'h0070 -> anode shows 1110/0 and 1101/7, and digit-2/3 slots are 1111; without the macro, all four slots are enabled, showing 0,7,0,0.
